vr_fwd_packer: RTL and testbench
================================

VR_FWD_PACKER -- requirements
Module: vr_fwd_packer

Interface
REQ-001 SHALL have parameter number_words, default 128, meaning 64-bit words per frame (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port consumer_data  decoupled_vr_if.slave  64-bit data  word stream in (valid, ready, data).
REQ-005 SHALL have port data_forward_in  data_forward_if.data_forward_in  rdy + number_words x 64  frame offered downstream.
REQ-006 SHALL have port frame_take  input  1  downstream has consumed the offered frame this cycle.
REQ-007 SHALL have port flush  input  1  discard the partially filled frame.
REQ-008 SHALL have port frames_sent  output  32  count of frames taken, wraps modulo 2^32.
REQ-009 SHALL have port take_err  output  1  sticky flag: frame_take seen while no frame was offered.

Function
REQ-010 SHALL hold two frame buffers (ping-pong), each number_words x 64 bits.
REQ-011 SHALL track wr_sel (fill buffer), rd_sel (offer buffer), wcnt (0..number_words-1) and full_cnt (0..2).
REQ-012 SHALL drive consumer_data.ready = (full_cnt < 2) & ~flush, combinationally from registers and flush.
REQ-013 SHALL, on consumer_data.valid & ready, write data to buffer[wr_sel][wcnt] and increment wcnt.
REQ-014 SHALL, when the accepted word has wcnt == number_words-1, set wcnt to 0, toggle wr_sel and increment full_cnt.
REQ-015 SHALL store word k of a frame at index k of data_forward_in.data.
REQ-016 SHALL drive data_forward_in.rdy = (full_cnt > 0) and data_forward_in.data = buffer[rd_sel], both from registers only.
REQ-017 SHALL raise rdy in the cycle after the last word of a frame is accepted (latency 1 cycle).
REQ-018 SHALL hold data_forward_in.data stable while rdy is high and frame_take is low.
REQ-019 SHALL, on frame_take & rdy, toggle rd_sel, decrement full_cnt and increment frames_sent; the next frame, if any, is visible the following cycle.
REQ-020 SHALL leave full_cnt unchanged on simultaneous frame completion and frame_take, while still applying both pointer updates.
REQ-021 SHALL ignore frame_take while rdy is low, leave all pointers unchanged, and set take_err until reset.
REQ-022 SHALL, on flush, set wcnt to 0 and keep completed frames and rd_sel, wr_sel and full_cnt unchanged; a frame_take in the same cycle is still honoured.
REQ-023 SHALL deassert ready with full_cnt == 2 and accept no word until a frame_take.

Reset
REQ-024 SHALL, on rst, clear wcnt, wr_sel, rd_sel, full_cnt, frames_sent and take_err; outputs read ready=1, rdy=0, frames_sent=0, take_err=0.
REQ-025 SHALL, on rst mid-frame or mid-offer, discard all buffered words; buffer contents need no reset, and data_forward_in.data is don't-care while rdy=0.

Structure
REQ-026 SHALL take the 64-bit word width and the frame-count width (32) as constants from acc_pkg.
REQ-027 SHALL be a single module with no sub-modules; the buffer may be flops or a two-bank register array.

Verification
REQ-028 SHALL cover basic fill: 128 words 0..127 at full rate -> rdy=1 exactly one cycle after word 127; data[k]=k; frame_take -> frames_sent=1 and rdy=0 next cycle.
REQ-029 SHALL cover backpressure: 256 words with no take -> ready=0 after word 255; frame_take -> frame 2 (data[k]=128+k) offered next cycle; ready=1 again.
REQ-030 SHALL cover simultaneous events: frame_take in the same cycle word 255 is accepted -> full_cnt stays 1; rdy stays 1; the offer switches to frame 2.
REQ-031 SHALL cover flush: flush after 50 words, then 128 words 1000..1127 -> offered frame holds 1000..1127; no residue of the first 50 words.
REQ-032 SHALL cover error and reset: frame_take with rdy=0 -> take_err=1 and persists; rst after 70 words -> rdy=0, take_err=0, and the next 128 words form frame 1 correctly.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared widths and small helpers for the accelerator datapath blocks.
// The word width and frame counter width are defined here so every stage agrees on them.
package acc_pkg;

    localparam int WORD_W      = 64;
    localparam int FRAME_CNT_W = 32;
    localparam int BANKS       = 2;

    // Occupancy of a two-bank ping-pong store.
    typedef logic [1:0] occ_t;

    function automatic occ_t occ_update(input occ_t cur, input logic add, input logic sub);
        occ_t nxt;
        nxt = cur;
        if (add && !sub) begin
            nxt = cur + 2'd1;
        end else if (sub && !add) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vr_fwd_packer_if.sv
// Handshake interfaces around the packer: a valid/ready word stream in,
// and a whole-frame offer (rdy + data) out.
interface decoupled_vr_if #(
    parameter int W = 64
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport slave  (input valid, input data, output ready);
    modport master (output valid, output data, input ready);
endinterface

interface data_forward_if #(
    parameter int NW = 128,
    parameter int W  = 64
);
    logic                 rdy;
    logic [NW-1:0][W-1:0] data;

    modport data_forward_in  (output rdy, output data);
    modport data_forward_out (input rdy, input data);
endinterface

// File: rtl/vr_fwd_packer.sv
// Packs a 64-bit word stream into number_words-word frames using two ping-pong
// buffers, offering each completed frame downstream until it is taken.
module vr_fwd_packer
    import acc_pkg::*;
#(
    parameter int number_words = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    decoupled_vr_if.slave              consumer_data,
    data_forward_if.data_forward_in    data_forward_in,
    input  logic                       frame_take,
    input  logic                       flush,
    output logic [FRAME_CNT_W-1:0]     frames_sent,
    output logic                       take_err
);

    localparam int WCNT_W = (number_words > 1) ? $clog2(number_words) : 1;
    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(number_words - 1);

    logic [number_words-1:0][WORD_W-1:0] r_buf [BANKS];

    logic                   r_wr_sel;
    logic                   r_rd_sel;
    logic [WCNT_W-1:0]      r_wcnt;
    occ_t                   r_full_cnt;
    logic [FRAME_CNT_W-1:0] r_frames_sent;
    logic                   r_take_err;

    logic w_ready;
    logic w_rdy;
    logic w_accept;
    logic w_complete;
    logic w_take;
    occ_t w_full_cnt_next;

    assign w_ready    = (r_full_cnt < 2'd2) & ~flush;
    assign w_rdy      = (r_full_cnt != 2'd0);
    assign w_accept   = consumer_data.valid & w_ready;
    assign w_complete = w_accept & (r_wcnt == LAST_IDX);
    assign w_take     = frame_take & w_rdy;

    // A completion and a take in the same cycle cancel out in the occupancy.
    always_comb begin
        w_full_cnt_next = occ_update(r_full_cnt, w_complete, w_take);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_sel      <= 1'b0;
            r_rd_sel      <= 1'b0;
            r_wcnt        <= '0;
            r_full_cnt    <= 2'd0;
            r_frames_sent <= '0;
            r_take_err    <= 1'b0;
        end else begin
            if (flush) begin
                r_wcnt <= '0;
            end else if (w_accept) begin
                r_wcnt <= (r_wcnt == LAST_IDX) ? '0 : r_wcnt + 1'b1;
            end
            if (w_complete) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_take) begin
                r_rd_sel      <= ~r_rd_sel;
                r_frames_sent <= r_frames_sent + 1'b1;
            end
            r_full_cnt <= w_full_cnt_next;
            if (frame_take && !w_rdy) begin
                r_take_err <= 1'b1;
            end
        end
    end

    // Frame storage is not reset; a stale bank is never offered because rdy gates it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_sel][r_wcnt] <= consumer_data.data;
        end
    end

    assign consumer_data.ready  = w_ready;
    assign data_forward_in.rdy  = w_rdy;
    assign data_forward_in.data = r_buf[r_rd_sel];
    assign frames_sent          = r_frames_sent;
    assign take_err             = r_take_err;

endmodule

// File: tb/tb_vr_fwd_packer.sv
// Directed self-checking bench for vr_fwd_packer with the default 128-word frame.
module tb_vr_fwd_packer;
    import acc_pkg::*;

    localparam int NW = 128;

    logic                   clk;
    logic                   rst;
    logic                   frame_take;
    logic                   flush;
    logic [FRAME_CNT_W-1:0] frames_sent;
    logic                   take_err;

    int n_cmp;
    int n_fail;

    decoupled_vr_if #(.W(WORD_W))             cons ();
    data_forward_if #(.NW(NW), .W(WORD_W))    fwd ();

    vr_fwd_packer #(.number_words(NW)) dut (
        .clk             (clk),
        .rst             (rst),
        .consumer_data   (cons),
        .data_forward_in (fwd),
        .frame_take      (frame_take),
        .flush           (flush),
        .frames_sent     (frames_sent),
        .take_err        (take_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic send_words(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cons.valid = 1'b1;
            cons.data  = base + 64'(i);
        end
    endtask

    task automatic check_frame(input string name, input logic [63:0] base);
        logic [63:0] exp;
        for (int k = 0; k < NW; k++) begin
            exp = base + 64'(k);
            n_cmp++;
            if (fwd.data[k] !== exp) begin
                n_fail++;
                $display("[TB] FAIL %s word %0d: got %0d expected %0d", name, k, fwd.data[k], exp);
            end
        end
    endtask

    task automatic check_count(input string name, input logic [31:0] exp);
        n_cmp++;
        if (frames_sent !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, frames_sent, exp);
        end
    endtask

    task automatic take_one;
        @(negedge clk);
        cons.valid = 1'b0;
        frame_take = 1'b1;
        @(negedge clk);
        frame_take = 1'b0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        cons.valid = 1'b0;
        cons.data  = '0;
        frame_take = 1'b0;
        flush      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("reset ready", cons.ready, 1'b1);
        chk1("reset rdy", fwd.rdy, 1'b0);
        chk1("reset take_err", take_err, 1'b0);
        check_count("reset frames_sent", 32'd0);
    endtask

    task automatic test_basic_fill;
        send_words(64'd0, NW - 1);
        @(negedge clk);
        chk1("fill rdy before last word", fwd.rdy, 1'b0);
        chk1("fill ready", cons.ready, 1'b1);
        cons.valid = 1'b1;
        cons.data  = 64'd127;
        @(negedge clk);
        cons.valid = 1'b0;
        chk1("fill rdy after last word", fwd.rdy, 1'b1);
        check_frame("fill data", 64'd0);
        frame_take = 1'b1;
        @(negedge clk);
        frame_take = 1'b0;
        check_count("fill frames_sent", 32'd1);
        chk1("fill rdy after take", fwd.rdy, 1'b0);
    endtask

    task automatic test_backpressure;
        send_words(64'd0, 2 * NW);
        @(negedge clk);
        cons.valid = 1'b0;
        chk1("bp ready when full", cons.ready, 1'b0);
        chk1("bp rdy when full", fwd.rdy, 1'b1);
        check_frame("bp first frame", 64'd0);
        // This word must be refused while both banks are full.
        cons.valid = 1'b1;
        cons.data  = 64'd999;
        @(negedge clk);
        cons.valid = 1'b0;
        check_frame("bp first frame held", 64'd0);
        take_one();
        chk1("bp ready after take", cons.ready, 1'b1);
        chk1("bp rdy second frame", fwd.rdy, 1'b1);
        check_frame("bp second frame", 64'd128);
        check_count("bp frames_sent", 32'd2);
        take_one();
        chk1("bp drained rdy", fwd.rdy, 1'b0);
        check_count("bp frames_sent drained", 32'd3);
    endtask

    task automatic test_simultaneous;
        send_words(64'd500, 2 * NW - 1);
        @(negedge clk);
        chk1("simul rdy before", fwd.rdy, 1'b1);
        cons.valid = 1'b1;
        cons.data  = 64'd755;
        frame_take = 1'b1;
        @(negedge clk);
        cons.valid = 1'b0;
        frame_take = 1'b0;
        chk1("simul rdy stays", fwd.rdy, 1'b1);
        chk1("simul ready (one frame held)", cons.ready, 1'b1);
        check_frame("simul switched offer", 64'd628);
        check_count("simul frames_sent", 32'd4);
        take_one();
        chk1("simul drained rdy", fwd.rdy, 1'b0);
        check_count("simul frames_sent drained", 32'd5);
    endtask

    task automatic test_flush;
        send_words(64'd7000, 50);
        @(negedge clk);
        cons.valid = 1'b0;
        flush      = 1'b1;
        #1;
        chk1("flush ready low", cons.ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk1("flush rdy after flush", fwd.rdy, 1'b0);
        send_words(64'd1000, NW);
        @(negedge clk);
        cons.valid = 1'b0;
        chk1("flush rdy", fwd.rdy, 1'b1);
        check_frame("flush frame", 64'd1000);
        take_one();
        check_count("flush frames_sent", 32'd6);
        chk1("flush drained rdy", fwd.rdy, 1'b0);
    endtask

    task automatic test_error_reset;
        @(negedge clk);
        frame_take = 1'b1;
        @(negedge clk);
        frame_take = 1'b0;
        chk1("err take_err set", take_err, 1'b1);
        chk1("err rdy unchanged", fwd.rdy, 1'b0);
        check_count("err frames_sent unchanged", 32'd6);
        repeat (4) @(negedge clk);
        chk1("err take_err sticky", take_err, 1'b1);
        send_words(64'd2000, 70);
        @(negedge clk);
        cons.valid = 1'b0;
        chk1("err partial rdy", fwd.rdy, 1'b0);
        rst = 1'b1;
        #1;
        chk1("rst rdy", fwd.rdy, 1'b0);
        chk1("rst take_err", take_err, 1'b0);
        chk1("rst ready", cons.ready, 1'b1);
        check_count("rst frames_sent", 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_words(64'd3000, NW);
        @(negedge clk);
        cons.valid = 1'b0;
        chk1("post-rst rdy", fwd.rdy, 1'b1);
        check_frame("post-rst frame", 64'd3000);
        take_one();
        check_count("post-rst frames_sent", 32'd1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic_fill();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_error_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
